// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: BOOT/FETCH/DRAIN sequencer with a one-entry buffer.
// Optional macro FETCH_REDIRECT_CNT_EN adds a redirect cycle counter output.
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic        is_j_instr,
  input  logic        is_jr_instr,
  input  logic [31:0] branch_pc,
  input  logic        trap_req,
  input  logic [31:0] trap_vector,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
`ifdef FETCH_REDIRECT_CNT_EN
  output logic [31:0] redirect_count,
`endif
  output logic        instr_valid
);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] hold_addr;
  logic        pending;   // request issued to memory and not yet acknowledged

  logic        redirect;
  logic [31:0] target;
  logic        consumed;

  assign redirect = trap_req | branch_taken | is_j_instr | is_jr_instr;
  assign target   = trap_req ? trap_vector : branch_pc;
  assign consumed = instr_valid & ~stall;

  // An outstanding request keeps req/addr frozen even if the consumer stalls
  // or the pc is redirected underneath it.
  // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    imem_req  = 1'b0;
    imem_addr = pending ? hold_addr : pc;
    unique case (state)
      FETCH:   imem_req = pending | ~instr_valid | consumed;
      DRAIN:   imem_req = 1'b1;
      default: imem_req = 1'b0;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
  // NOTE: reset is synchronous, so it only takes effect on a rising clk edge.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= BOOT;
      pc          <= RESET_PC;
      hold_addr   <= RESET_PC;
      pending     <= 1'b0;
      instr_valid <= 1'b0;
      instr       <= '0;
      instr_pc    <= '0;
    end else begin
      unique case (state)
        BOOT: begin
          state   <= FETCH;
          pc      <= RESET_PC;
          pending <= 1'b0;
        end

        FETCH: begin
          if (consumed) instr_valid <= 1'b0;
          if (redirect) begin
            pc          <= target;
            instr_valid <= 1'b0;
            if (imem_req && !imem_ack) begin
              // Memory still owes us a word for the old stream; wait it out.
              state     <= DRAIN;
              pending   <= 1'b1;
              hold_addr <= imem_addr;
            end else begin
              pending <= 1'b0;
            end
          end else if (imem_req && imem_ack) begin
            instr       <= imem_rdata;
            instr_pc    <= pc;
            instr_valid <= 1'b1;
            pc          <= pc + 32'd1;
            pending     <= 1'b0;
          end else if (imem_req) begin
            pending   <= 1'b1;
            hold_addr <= imem_addr;
          end
        end

        DRAIN: begin
          if (redirect) begin
            pc          <= target;
            instr_valid <= 1'b0;
          end
          // The returning word belongs to the abandoned stream; the buffer is left alone.
          if (imem_ack) begin
            state   <= FETCH;
            pending <= 1'b0;
          end
        end

        default: begin
          state   <= BOOT;
          pending <= 1'b0;
        end
      endcase
    end
  end

`ifdef FETCH_REDIRECT_CNT_EN
  always_ff @(posedge clk) begin
    if (!reset)        redirect_count <= '0;
    else if (redirect) redirect_count <= redirect_count + 32'd1;
  end
`endif

endmodule
